// File: rtl/z80_int_daisy_arbiter.sv
// Z80 mode-2 interrupt daisy-chain arbiter: per-source IP/IUS tracking, int_n generation,
// vector supply during interrupt acknowledge, and RETI (ED 4D) snooping to retire service.
module z80_int_daisy_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clock_ena,
  input  logic [NUM_SRC-1:0]   int_req,
  input  logic [8*NUM_SRC-1:0] vec_in,
  input  logic [7:0]           cpu_din,
  input  logic                 m1_n,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 iei,
  output logic                 ieo,
  output logic                 int_n,
  output logic [7:0]           dout,
  output logic                 dout_en,
  output logic [NUM_SRC-1:0]   ius
);

  typedef enum logic {
    RETI_IDLE,
    RETI_GOT_ED
  } reti_state_t;

  reti_state_t        reti_state;
  logic [NUM_SRC-1:0] ip;
  logic [NUM_SRC-1:0] ius_q;
  logic [7:0]         vec_q;
  logic               ack_q;
  logic               owned;
  logic               fetch_q;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] win_onehot;
  logic [NUM_SRC-1:0] set_mask;
  logic [NUM_SRC-1:0] clr_mask;
  logic [7:0]         win_vec;
  logic               blocked;
  logic               any_eligible;
  logic               ack;
  logic               ack_start;
  logic               grant;
  logic               fetch_lvl;
  logic               fetch_step;
  logic               reti_hit;

  // A source is blocked by its own IUS bit and by every higher-priority IUS bit.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional logic,
    // so no path leaves it unassigned and no latch is inferred.
    blocked  = 1'b0;
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      blocked     = blocked | ius_q[i];
      eligible[i] = ip[i] & ~blocked;
    end
  end

  assign any_eligible = |eligible;
  assign win_onehot   = eligible & (~eligible + NUM_SRC'(1));

  always_comb begin
    win_vec = 8'hFF;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_onehot[i]) win_vec = vec_in[8*i +: 8];
    end
  end

  assign ack       = ~m1_n & ~iorq_n;
  assign ack_start = clock_ena & ack & ~ack_q;
  assign grant     = ack_start & iei & any_eligible;
  assign set_mask  = grant ? win_onehot : '0;

  // Opcode fetches are edge-detected so a multi-cycle M1 read advances the decoder once.
  assign fetch_lvl  = ~m1_n & ~rd_n & iorq_n;
  assign fetch_step = clock_ena & fetch_lvl & ~fetch_q;
  assign reti_hit   = fetch_step & (reti_state == RETI_GOT_ED) & (cpu_din == 8'h4D);
  assign clr_mask   = (reti_hit & iei) ? (ius_q & (~ius_q + NUM_SRC'(1))) : '0;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the reset is synchronous and overrides clock_ena.
    if (!reset_n) begin
      ip         <= '0;
      ius_q      <= '0;
      vec_q      <= 8'hFF;
      ack_q      <= 1'b0;
      owned      <= 1'b0;
      fetch_q    <= 1'b0;
      reti_state <= RETI_IDLE;
    end else if (clock_ena) begin
      ack_q   <= ack;
      fetch_q <= fetch_lvl;
      // A request coinciding with the grant keeps IP set; a set IUS bit beats a RETI clear.
      ip      <= (ip & ~set_mask) | int_req;
      ius_q   <= (ius_q & ~clr_mask) | set_mask;

      if (grant) begin
        vec_q <= win_vec;
        owned <= 1'b1;
      end else if (ack_start || !ack) begin
        owned <= 1'b0;
      end

      if (fetch_step) begin
        unique case (reti_state)
          RETI_IDLE:   reti_state <= (cpu_din == 8'hED) ? RETI_GOT_ED : RETI_IDLE;
          RETI_GOT_ED: reti_state <= (cpu_din == 8'hED) ? RETI_GOT_ED : RETI_IDLE;
          default:     reti_state <= RETI_IDLE;
        endcase
      end
    end
  end

  assign int_n   = ~(iei & any_eligible);
  assign ieo     = iei & ~|ius_q & int_n;
  assign dout_en = ack & owned;
  assign dout    = dout_en ? vec_q : 8'hFF;
  assign ius     = ius_q;

endmodule

// File: tb/tb_z80_int_daisy_arbiter.sv
// Scoreboard bench for z80_int_daisy_arbiter: directed scenarios then random traffic,
// checked against a pending/in-service model of the daisy-chain rules.
module tb_z80_int_daisy_arbiter;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           clock_ena;
  logic [N-1:0]   int_req;
  logic [8*N-1:0] vec_in;
  logic [7:0]     cpu_din;
  logic           m1_n, iorq_n, rd_n, iei;
  logic           ieo, int_n, dout_en;
  logic [7:0]     dout;
  logic [N-1:0]   ius;

  z80_int_daisy_arbiter #(.NUM_SRC(N)) dut (
    .clock(clock), .reset_n(reset_n), .clock_ena(clock_ena), .int_req(int_req),
    .vec_in(vec_in), .cpu_din(cpu_din), .m1_n(m1_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .iei(iei), .ieo(ieo), .int_n(int_n), .dout(dout), .dout_en(dout_en), .ius(ius)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending flags, in-service flags, per-source vectors, RETI prefix flag.
  bit         m_ip[N];
  bit         m_ius[N];
  bit         m_prev_ed;
  logic [7:0] vec[N];

  typedef struct {
    bit         en;
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];

  function automatic int m_winner();
    for (int i = 0; i < N; i++) begin
      bit served_above = 0;
      for (int j = 0; j <= i; j++) if (m_ius[j]) served_above = 1;
      if (m_ip[i] && !served_above) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ius_vec();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_ius[i];
    return r;
  endfunction

  function automatic bit m_int_n();
    return !(iei && m_winner() >= 0);
  endfunction

  function automatic bit m_ieo();
    return iei && (m_ius_vec() == '0) && m_int_n();
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".int_n"}, int_n, m_int_n());
    check({tag, ".ieo"}, ieo, m_ieo());
    check({tag, ".ius"}, ius, m_ius_vec());
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_vec();
    for (int i = 0; i < N; i++) vec_in[8*i +: 8] = vec[i];
  endtask

  task automatic pulse_req(input logic [N-1:0] mask);
    int_req = mask;
    tick();
    int_req = '0;
    if (clock_ena) for (int i = 0; i < N; i++) if (mask[i]) m_ip[i] = 1;
  endtask

  // Full acknowledge cycle; req_mask is pulsed on the same edge as the ack start.
  task automatic do_ack(input logic [N-1:0] req_mask);
    int   w;
    exp_t e;
    w = iei ? m_winner() : -1;
    if (w >= 0) begin
      e.en = 1; e.v = vec[w];
      m_ius[w] = 1;
      m_ip[w]  = 0;
    end else begin
      e.en = 0; e.v = 8'hFF;
    end
    for (int i = 0; i < N; i++) if (req_mask[i]) m_ip[i] = 1;
    sb.push_back(e);
    m1_n = 1'b0; iorq_n = 1'b0; int_req = req_mask;
    tick();
    int_req = '0;
    tick();
    tick();
    m1_n = 1'b1; iorq_n = 1'b1;
    tick();
    check("post_ack.dout_en", dout_en, 1'b0);
    check("post_ack.dout", dout, 8'hFF);
  endtask

  task automatic fetch(input logic [7:0] b);
    cpu_din = b; m1_n = 1'b0; rd_n = 1'b0;
    tick();
    m1_n = 1'b1; rd_n = 1'b1;
    tick();
    if (m_prev_ed && b == 8'h4D && iei) begin
      for (int i = 0; i < N; i++) if (m_ius[i]) begin
        m_ius[i] = 0;
        break;
      end
    end
    m_prev_ed = (b == 8'hED);
  endtask

  task automatic reti();
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  // Monitor: the vector is checked on the 2nd and 3rd cycles of every acknowledge.
  initial begin
    int   cnt = 0;
    exp_t e;
    e.en = 0; e.v = 8'hFF;
    forever begin
      @(negedge clock);
      if (!m1_n && !iorq_n && reset_n) begin
        cnt++;
        if (cnt == 1) begin
          check("sb_has_entry", sb.size() > 0, 1'b1);
          if (sb.size() > 0) e = sb.pop_front();
        end else begin
          check("ack.dout_en", dout_en, e.en);
          check("ack.dout", dout, e.en ? e.v : 8'hFF);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      vec[i] = 8'(8'h10 + 2 * i);
      m_ip[i] = 0; m_ius[i] = 0;
    end
    m_prev_ed = 0;
    apply_vec();
    reset_n = 1'b0; clock_ena = 1'b1; iei = 1'b1;
    m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; cpu_din = 8'h00;
    int_req = 4'b1111;

    // Reset with requests held active
    tick(); tick();
    check("rst.int_n", int_n, 1'b1);
    check("rst.ius", ius, 4'b0000);
    check("rst.dout", dout, 8'hFF);
    check("rst.dout_en", dout_en, 1'b0);
    int_req = '0; reset_n = 1'b1;
    tick();
    check_state("rst_release");

    // Single request from source 2
    pulse_req(4'b0100);
    check_state("single_req");
    do_ack('0);
    check_state("single_ack");
    reti();
    check_state("single_reti");

    // Priority: 1 beats 3; 3 waits for RETI
    pulse_req(4'b1010);
    check_state("prio_req");
    do_ack('0);
    check_state("prio_ack1");
    reti();
    check_state("prio_reti1");
    do_ack('0);
    check_state("prio_ack3");
    reti();
    check_state("prio_reti3");

    // Nesting: 0 interrupts service of 2
    pulse_req(4'b0100);
    do_ack('0);
    pulse_req(4'b0001);
    check_state("nest_req0");
    do_ack('0);
    check_state("nest_ack0");
    reti();
    check_state("nest_reti1");
    reti();
    check_state("nest_reti2");

    // RETI decode edges
    pulse_req(4'b0010);
    do_ack('0);
    fetch(8'hED); fetch(8'hED); fetch(8'h4D);
    check_state("reti_ed_ed_4d");
    pulse_req(4'b0010);
    do_ack('0);
    fetch(8'hED); fetch(8'h00); fetch(8'h4D);
    check_state("reti_ed_00_4d");
    iei = 1'b0;
    reti();
    check_state("reti_iei0");
    iei = 1'b1;
    reti();
    check_state("reti_iei1");

    // Chain blocking and own in-service blocking
    iei = 1'b0;
    pulse_req(4'b0001);
    check_state("chain_blocked");
    do_ack('0);
    check_state("chain_ack_blocked");
    iei = 1'b1;
    #1;
    check_state("chain_open");
    do_ack('0);
    pulse_req(4'b0001);
    check_state("own_ius_block");
    reti();
    check_state("own_ius_reti");
    do_ack('0);
    reti();
    check_state("own_ius_done");

    // Clock enable low: requests ignored
    clock_ena = 1'b0;
    pulse_req(4'b0100);
    clock_ena = 1'b1;
    tick();
    check_state("cke_hold");

    // Request coinciding with its own grant stays pending
    pulse_req(4'b0010);
    do_ack(4'b0010);
    check_state("simul_ack");
    reti();
    check_state("simul_reti");
    do_ack('0);
    reti();
    check_state("simul_done");

    // Randomised traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 6))
        0, 1: pulse_req(N'($urandom));
        2:    do_ack(($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
        3:    reti();
        4: begin
          case ($urandom_range(0, 3))
            0: fetch(8'hED);
            1: fetch(8'h4D);
            2: fetch(8'h00);
            default: fetch(8'($urandom));
          endcase
        end
        5: begin
          iei = ($urandom_range(0, 3) != 0);
          #1;
        end
        default: begin
          for (int i = 0; i < N; i++) vec[i] = 8'($urandom);
          apply_vec();
        end
      endcase
      check_state("rand");
    end

    tick();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
